// File: rtl/reg_bank_pkg.sv
// Shared types and defaults for the register bank with scoreboard.
// Holds the clear-engine state encoding and default geometry constants.
package reg_bank_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_NUM_REGS = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } clr_state_t;

endpackage

// File: rtl/reg_bank_rdport.sv
// Read port: select mux with same-cycle write bypass and pending lookup.
// Latency: combinational, zero cycles.
// Backpressure: none; always presents data for the current select.
module reg_bank_rdport
    import reg_bank_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int BYPASS   = 1,
    parameter int ZERO_R0  = 0,
    parameter int SEL_W    = $clog2(NUM_REGS)
) (
    input  logic [NUM_REGS-1:0][DATA_W-1:0] regs,
    input  logic [NUM_REGS-1:0]             pend,
    input  logic                            byp_en,
    input  logic [SEL_W-1:0]                byp_sel,
    input  logic [DATA_W-1:0]               byp_data,
    input  logic [SEL_W-1:0]                rd_sel,
    output logic [DATA_W-1:0]               rd_data,
    output logic                            rd_pend
);

    logic sel_ok;

    // byp_en arrives already qualified for range, r0 and clear-engine state
    assign sel_ok = (32'(rd_sel) < NUM_REGS) && !(ZERO_R0 != 0 && rd_sel == '0);

    always_comb begin
        rd_data = '0;
        rd_pend = 1'b0;
        if (sel_ok) begin
            if (BYPASS != 0 && byp_en && byp_sel == rd_sel) begin
                rd_data = byp_data;
                rd_pend = 1'b0;
            end else begin
                rd_data = regs[rd_sel];
                rd_pend = pend[rd_sel];
            end
        end
    end

endmodule

// File: rtl/reg_bank_sb.sv
// Register bank with one write port, two read ports, pending scoreboard and clear engine.
// Latency: reads combinational; writes/issues land at the next edge; clear takes NUM_REGS+1 cycles.
// Backpressure: writes and issues are dropped while the clear engine runs; caller stalls on clr_busy.
module reg_bank_sb
    import reg_bank_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int BYPASS   = 1,
    parameter int ZERO_R0  = 0,
    localparam int SEL_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [SEL_W-1:0]  wr_sel,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              issue_en,
    input  logic [SEL_W-1:0]  issue_sel,
    input  logic [SEL_W-1:0]  rd1_sel,
    output logic [DATA_W-1:0] rd1_data,
    output logic              rd1_pend,
    input  logic [SEL_W-1:0]  rd2_sel,
    output logic [DATA_W-1:0] rd2_data,
    output logic              rd2_pend,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done
);

    logic [NUM_REGS-1:0][DATA_W-1:0] regs;
    logic [NUM_REGS-1:0]             pend;
    clr_state_t                      state;
    logic [SEL_W-1:0]                clr_idx;
    logic                            idle;
    logic                            wr_hit;
    logic                            iss_hit;

    assign idle    = (state == IDLE);
    assign wr_hit  = wr_en && idle && (32'(wr_sel) < NUM_REGS)
                     && !(ZERO_R0 != 0 && wr_sel == '0);
    assign iss_hit = issue_en && idle && (32'(issue_sel) < NUM_REGS)
                     && !(ZERO_R0 != 0 && issue_sel == '0);

    // Issue is applied after write so a same-cycle issue leaves the register pending
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs <= '0;
            pend <= '0;
        end else if (state == CLEAR) begin
            regs[clr_idx] <= '0;
            pend[clr_idx] <= 1'b0;
        end else begin
            if (wr_hit) begin
                regs[wr_sel] <= wr_data;
                pend[wr_sel] <= 1'b0;
            end
            if (iss_hit) begin
                pend[issue_sel] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            clr_idx  <= '0;
            clr_busy <= 1'b0;
            clr_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    clr_done <= 1'b0;
                    if (clr_req) begin
                        state    <= CLEAR;
                        clr_idx  <= '0;
                        clr_busy <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (32'(clr_idx) == NUM_REGS - 1) begin
                        state    <= DONE;
                        clr_busy <= 1'b0;
                        clr_done <= 1'b1;
                    end else begin
                        clr_idx <= clr_idx + SEL_W'(1);
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    clr_idx  <= '0;
                    clr_done <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    clr_idx  <= '0;
                    clr_busy <= 1'b0;
                    clr_done <= 1'b0;
                end
            endcase
        end
    end

    reg_bank_rdport #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .BYPASS   (BYPASS),
        .ZERO_R0  (ZERO_R0),
        .SEL_W    (SEL_W)
    ) u_rd1 (
        .regs     (regs),
        .pend     (pend),
        .byp_en   (wr_hit),
        .byp_sel  (wr_sel),
        .byp_data (wr_data),
        .rd_sel   (rd1_sel),
        .rd_data  (rd1_data),
        .rd_pend  (rd1_pend)
    );

    reg_bank_rdport #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .BYPASS   (BYPASS),
        .ZERO_R0  (ZERO_R0),
        .SEL_W    (SEL_W)
    ) u_rd2 (
        .regs     (regs),
        .pend     (pend),
        .byp_en   (wr_hit),
        .byp_sel  (wr_sel),
        .byp_data (wr_data),
        .rd_sel   (rd2_sel),
        .rd_data  (rd2_data),
        .rd_pend  (rd2_pend)
    );

endmodule
